// File: rtl/vp_result_checker.sv
// vp_result_checker: holds each value-predicted load in an in-order FIFO until
// the D-cache returns real data, then retires it (hit) or raises a one-shot
// recovery request (recover) carrying the checkpoint PC and the correct data.
// Optional: define VP_CHECK_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module vp_result_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pred_valid,
  input  logic [DATA_WIDTH-1:0]   pred_pc,
  input  logic [DATA_WIDTH-1:0]   pred_value,
  output logic                    pred_ready,
  input  logic                    dc_valid,
  input  logic [DATA_WIDTH-1:0]   dc_data,
  input  logic                    recovery_done,
  input  logic                    flush,
  output logic                    recover,
  output logic [DATA_WIDTH-1:0]   recover_pc,
  output logic [DATA_WIDTH-1:0]   correct_value,
  output logic                    hit,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    orphan_err
`ifdef VP_CHECK_STATS_EN
  ,
  output logic [15:0]             hit_cnt,
  output logic [15:0]             miss_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VERIFY   = 2'd1,
    WAIT_REC = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic                    hit_q;
  logic                    recover_q;
  logic                    orphan_q;
  logic [DATA_WIDTH-1:0]   recover_pc_q;
  logic [DATA_WIDTH-1:0]   correct_value_q;

  logic [DATA_WIDTH-1:0]   pc_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]   val_mem [DEPTH];

  logic                    pop;
  logic                    push;
  logic                    head_match;
  logic                    match;
  logic                    mismatch;

  // Handshake and compare decode for the current cycle
  always_comb begin
    pop        = dc_valid & (count_q != '0);
    pred_ready = (state_q != WAIT_REC) & ((count_q < CW'(DEPTH)) | pop);
    push       = pred_valid & pred_ready;
    head_match = (dc_data == val_mem[rd_ptr_q]);
    match      = pop & head_match;
    mismatch   = pop & ~head_match;
    count_d    = count_q + CW'(push) - CW'(match);
  end

  // Prediction storage; contents need no reset since count qualifies them
  always_ff @(posedge clk) begin
    if (push & ~flush) begin
      pc_mem[wr_ptr_q]  <= pred_pc;
      val_mem[wr_ptr_q] <= pred_value;
    end
  end

  // Control FSM, FIFO pointers and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      hit_q           <= 1'b0;
      recover_q       <= 1'b0;
      orphan_q        <= 1'b0;
      recover_pc_q    <= '0;
      correct_value_q <= '0;
    end else begin
      hit_q     <= 1'b0;
      recover_q <= 1'b0;
      if (flush) begin
        state_q  <= IDLE;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (dc_valid) orphan_q <= 1'b1;
            if (push) begin
              wr_ptr_q <= wr_ptr_q + PW'(1);
              count_q  <= count_q + CW'(1);
              state_q  <= VERIFY;
            end
          end
          VERIFY: begin
            if (mismatch) begin
              // Squash everything younger; the simultaneous push is lost too
              recover_q       <= 1'b1;
              recover_pc_q    <= pc_mem[rd_ptr_q];
              correct_value_q <= dc_data;
              wr_ptr_q        <= '0;
              rd_ptr_q        <= '0;
              count_q         <= '0;
              state_q         <= WAIT_REC;
            end else begin
              if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
              if (match) begin
                hit_q    <= 1'b1;
                rd_ptr_q <= rd_ptr_q + PW'(1);
              end
              count_q <= count_d;
              if (count_d == '0) state_q <= IDLE;
            end
          end
          WAIT_REC: begin
            if (recovery_done) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign hit           = hit_q;
  assign recover       = recover_q;
  assign recover_pc    = recover_pc_q;
  assign correct_value = correct_value_q;
  assign count         = count_q;
  assign orphan_err    = orphan_q;

`ifdef VP_CHECK_STATS_EN
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  // Saturating outcome counters, updated on the edge that raises hit/recover
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (!flush) begin
      if (match && (hit_cnt_q != 16'hFFFF))     hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (mismatch && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

`ifdef SIMULATION
  string       stats_last_event;
  int unsigned stats_event_total;

  function automatic void stats_event(input string name);
    stats_last_event  = name;
    stats_event_total = stats_event_total + 1;
  endfunction

  // Simulation-only event hook for every recovery request
  always @(posedge clk) begin
    if (!rst && !flush && mismatch) stats_event("VP_miss");
  end
`endif
`endif

endmodule

// File: tb/tb_vp_result_checker.sv
// Self-checking bench for vp_result_checker: a queue-based reference model is
// compared against the DUT every falling edge, plus directed literal checks.
module tb_vp_result_checker;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pred_valid = 1'b0;
  logic [DW-1:0] pred_pc = '0;
  logic [DW-1:0] pred_value = '0;
  logic          pred_ready;
  logic          dc_valid = 1'b0;
  logic [DW-1:0] dc_data = '0;
  logic          recovery_done = 1'b0;
  logic          flush = 1'b0;
  logic          recover;
  logic [DW-1:0] recover_pc;
  logic [DW-1:0] correct_value;
  logic          hit;
  logic [2:0]    count;
  logic          orphan_err;
`ifdef VP_CHECK_STATS_EN
  logic [15:0]   hit_cnt;
  logic [15:0]   miss_cnt;
`endif

  always #5 clk = ~clk;

  vp_result_checker #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_value(pred_value),
    .pred_ready(pred_ready),
    .dc_valid(dc_valid), .dc_data(dc_data),
    .recovery_done(recovery_done), .flush(flush),
    .recover(recover), .recover_pc(recover_pc), .correct_value(correct_value),
    .hit(hit), .count(count), .orphan_err(orphan_err)
`ifdef VP_CHECK_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: outstanding predictions as a plain queue
  typedef struct {
    logic [DW-1:0] pc;
    logic [DW-1:0] val;
  } ent_t;

  ent_t          mq[$];
  bit            m_wait_rec = 0;
  bit            m_hit = 0;
  bit            m_recover = 0;
  bit            m_orphan = 0;
  logic [DW-1:0] m_rpc = '0;
  logic [DW-1:0] m_cval = '0;
  int            m_hits = 0;
  int            m_miss = 0;

  function automatic bit m_ready();
    return !m_wait_rec && ((mq.size() < DEPTH) || (dc_valid && mq.size() > 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    bit rdy;
    rdy = m_ready();
    if (rst) begin
      mq.delete();
      m_wait_rec = 0; m_hit = 0; m_recover = 0; m_orphan = 0;
      m_rpc = '0; m_cval = '0; m_hits = 0; m_miss = 0;
    end else if (flush) begin
      mq.delete();
      m_wait_rec = 0; m_hit = 0; m_recover = 0;
    end else begin
      m_hit = 0; m_recover = 0;
      if (m_wait_rec) begin
        if (recovery_done) m_wait_rec = 0;
      end else if (dc_valid && mq.size() > 0 && dc_data != mq[0].val) begin
        m_recover = 1;
        m_rpc = mq[0].pc;
        m_cval = dc_data;
        mq.delete();
        m_wait_rec = 1;
        if (m_miss < 65535) m_miss++;
      end else begin
        if (dc_valid && mq.size() == 0) m_orphan = 1;
        if (dc_valid && mq.size() > 0) begin
          m_hit = 1;
          void'(mq.pop_front());
          if (m_hits < 65535) m_hits++;
        end
        if (pred_valid && rdy) mq.push_back('{pred_pc, pred_value});
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("hit", 32'(hit), 32'(m_hit));
      chk("recover", 32'(recover), 32'(m_recover));
      chk("recover_pc", recover_pc, m_rpc);
      chk("correct_value", correct_value, m_cval);
      chk("count", 32'(count), 32'(mq.size()));
      chk("orphan_err", 32'(orphan_err), 32'(m_orphan));
      chk("pred_ready", 32'(pred_ready), 32'(m_ready()));
`ifdef VP_CHECK_STATS_EN
      chk("hit_cnt", 32'(hit_cnt), 32'(m_hits));
      chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
`endif
    end
  end

  // One cycle of stimulus: inputs held across the next rising edge
  task automatic drive(input bit pv, input logic [DW-1:0] pc, input logic [DW-1:0] val,
                       input bit dv, input logic [DW-1:0] dd, input bit rd, input bit fl);
    pred_valid = pv; pred_pc = pc; pred_value = val;
    dc_valid = dv; dc_data = dd; recovery_done = rd; flush = fl;
    @(posedge clk);
    #2;
    pred_valid = 1'b0; pred_pc = '0; pred_value = '0;
    dc_valid = 1'b0; dc_data = '0; recovery_done = 1'b0; flush = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] pc, input logic [DW-1:0] val);
    drive(1, pc, val, 0, '0, 0, 0);
  endtask

  task automatic dc(input logic [DW-1:0] dd);
    drive(0, '0, '0, 1, dd, 0, 0);
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_pred_ready", 32'(pred_ready), 32'd1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_recover_pc", recover_pc, 32'd0);

    // Single prediction, matching return
    push(32'h400, 32'h11);
    chk("t1_count_after_push", 32'(count), 32'd1);
    dc(32'h11);
    chk("t1_hit", 32'(hit), 32'd1);
    chk("t1_count_after_hit", 32'(count), 32'd0);
    idle();
    chk("t1_hit_one_cycle", 32'(hit), 32'd0);

    // Hit then mismatch on the second entry
    push(32'h400, 32'h11);
    push(32'h404, 32'h22);
    dc(32'h11);
    chk("t2_hit", 32'(hit), 32'd1);
    dc(32'h99);
    chk("t2_recover", 32'(recover), 32'd1);
    chk("t2_recover_pc", recover_pc, 32'h404);
    chk("t2_correct_value", correct_value, 32'h99);
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_ready_wait", 32'(pred_ready), 32'd0);
    idle();
    chk("t2_recover_one_cycle", 32'(recover), 32'd0);
    dc(32'h5);
    chk("t2_no_orphan_in_wait", 32'(orphan_err), 32'd0);
    drive(0, '0, '0, 0, '0, 1, 0);
    chk("t2_ready_after_done", 32'(pred_ready), 32'd1);

    // Fill, dropped 5th push, push+matching pop when full, then drain
    push(32'h10, 32'h10);
    push(32'h14, 32'h11);
    push(32'h18, 32'h12);
    push(32'h1c, 32'h13);
    chk("t3_full_count", 32'(count), 32'd4);
    chk("t3_full_ready", 32'(pred_ready), 32'd0);
    push(32'h50, 32'h55);
    chk("t3_drop_count", 32'(count), 32'd4);
    drive(1, 32'h60, 32'h14, 1, 32'h10, 0, 0);
    chk("t3_pushpop_count", 32'(count), 32'd4);
    chk("t3_pushpop_hit", 32'(hit), 32'd1);
    dc(32'h11);
    dc(32'h12);
    dc(32'h13);
    dc(32'h14);
    chk("t3_drained_hit", 32'(hit), 32'd1);
    chk("t3_drained_count", 32'(count), 32'd0);

    // Orphan return while empty
    dc(32'h5);
    chk("t4_orphan", 32'(orphan_err), 32'd1);
    chk("t4_no_hit", 32'(hit), 32'd0);
    idle();
    chk("t4_orphan_sticky", 32'(orphan_err), 32'd1);

    // Flush beats a simultaneous mismatch
    push(32'h500, 32'h1);
    push(32'h504, 32'h2);
    push(32'h508, 32'h3);
    chk("t5_count3", 32'(count), 32'd3);
    drive(0, '0, '0, 1, 32'hdead, 0, 1);
    chk("t5_flush_count", 32'(count), 32'd0);
    chk("t5_flush_recover", 32'(recover), 32'd0);
    chk("t5_flush_rpc_kept", recover_pc, 32'h404);
    chk("t5_flush_ready", 32'(pred_ready), 32'd1);
    idle();

    // Async reset while waiting for recovery
    do_reset();
    push(32'h3f4, 32'h1);
    push(32'h3f8, 32'h2);
    push(32'h3fc, 32'h3);
    push(32'h404, 32'h4);
    dc(32'h1);
    dc(32'h2);
    dc(32'h3);
    dc(32'h77);
    chk("t6_recover_pc", recover_pc, 32'h404);
    chk("t6_correct_value", correct_value, 32'h77);
`ifdef VP_CHECK_STATS_EN
    chk("t6_hit_cnt", 32'(hit_cnt), 32'd3);
    chk("t6_miss_cnt", 32'(miss_cnt), 32'd1);
`endif
    idle();
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_recover_pc", recover_pc, 32'd0);
    chk("t6_rst_correct_value", correct_value, 32'd0);
    chk("t6_rst_recover", 32'(recover), 32'd0);
    chk("t6_rst_hit", 32'(hit), 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_orphan", 32'(orphan_err), 32'd0);
    chk("t6_rst_ready", 32'(pred_ready), 32'd1);
`ifdef VP_CHECK_STATS_EN
    chk("t6_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("t6_rst_miss_cnt", 32'(miss_cnt), 32'd0);
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    idle();
    chk("t6_no_pulse_after_release", 32'(recover | hit), 32'd0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vp_result_checker.md
Name: vp_result_checker

Overview:
- Sits directly downstream of the value-prediction path in the hazard controller. It consumes each speculative load value handed to the pipeline and holds it until the D-cache returns the real data.
- On each return it compares the real data with the predicted value. A match retires the entry; a mismatch raises a one-shot recovery request carrying the checkpoint PC and the correct data.
- Entries are kept in an in-order FIFO of outstanding predictions, managed by a 3-state FSM.

Parameters:
- DATA_WIDTH, 32, width of load data and PCs.
- DEPTH, 4, number of outstanding predictions; power of two, >=2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- pred_valid  in  1  a predicted value was issued this cycle.
- pred_pc  in  DATA_WIDTH  checkpoint PC of the predicted load.
- pred_value  in  DATA_WIDTH  value given to the pipeline.
- pred_ready  out  1  entry can be accepted.
- dc_valid  in  1  D-cache returned the real data for the oldest miss.
- dc_data  in  DATA_WIDTH  real load data.
- recovery_done  in  1  snapshot restore finished.
- flush  in  1  discard all outstanding entries, no recovery.
- recover  out  1  one-cycle pulse on mismatch.
- recover_pc  out  DATA_WIDTH  checkpoint PC; held until the next mismatch.
- correct_value  out  DATA_WIDTH  real data of the mismatched load; held with recover_pc.
- hit  out  1  one-cycle pulse on match.
- count  out  $clog2(DEPTH)+1  occupancy.
- orphan_err  out  1  sticky; set by dc_valid with no entry outstanding.

Behaviour:
- Reset (async, rst=1): FIFO empty, count=0, FSM=IDLE, recover=0, hit=0, recover_pc=0, correct_value=0, orphan_err=0. Since the FIFO is empty and the state is IDLE, pred_ready=1.
- FIFO pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count is a separate counter.
- pred_ready = (state != WAIT_REC) & (count < DEPTH | pop_this_cycle), where pop = dc_valid & count>0.
- A push when pred_ready=0 is dropped and does not change state.
- FSM states:
  - IDLE: count==0.
    - A push moves to VERIFY.
    - dc_valid sets orphan_err, is otherwise ignored, and produces no hit.
  - VERIFY: count>0.
    - On dc_valid, compare dc_data with the head pred_value, full-width equality.
    - Equal: hit=1 next cycle; pop the head. If count becomes 0 with no push in the same cycle, go to IDLE.
    - Unequal: recover=1 next cycle; recover_pc=head pred_pc; correct_value=dc_data; clear the whole FIFO (count=0, pointers=0). Any simultaneous push is discarded. Go to WAIT_REC.
  - WAIT_REC: pred_ready=0; dc_valid is ignored and does not set orphan_err. recovery_done returns the FSM to IDLE the next cycle.
- Latency: hit and recover are registered, asserted in the cycle after dc_valid, and last exactly 1 cycle.
- Simultaneous push and matching pop: both take effect and count is unchanged. This is legal at count==DEPTH.
- flush has priority over everything: FIFO cleared, FSM to IDLE, no hit or recover pulse; recover_pc and correct_value are kept.
- flush and mismatch in the same cycle: flush wins and recover stays 0.
- Reset asserted mid-operation clears everything asynchronously; no pulse is emitted on release.

Optional Feature:
- Macro VP_CHECK_STATS_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Both are saturating at 16'hFFFF and reset to 0.
  - They increment in the same cycle hit/recover is asserted.
  - Under SIMULATION, each mismatch also raises stats_event("VP_miss").
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then push pred (pc=0x400, val=0x11), then dc_valid dc_data=0x11 -> hit=1 for 1 cycle, count 1->0, FSM back to IDLE, recover=0.
- Push pc=0x400 val=0x11 and pc=0x404 val=0x22; dc_valid 0x11, then dc_valid 0x99 -> hit on the first; recover=1 with recover_pc=0x404 and correct_value=0x99; count=0; pred_ready=0 until recovery_done, then 1 one cycle later.
- Fill to DEPTH=4 -> pred_ready=0 and a 5th push is dropped. A push coinciding with a matching dc_valid is accepted and count stays 4.
- dc_valid while empty in IDLE -> orphan_err=1 and stays set; no hit.
- With 3 entries, assert flush together with a mismatching dc_valid -> count=0, FSM=IDLE, recover=0, recover_pc unchanged.
- Assert rst in WAIT_REC with recover_pc=0x404 -> all outputs immediately at reset values and pred_ready=1. With VP_CHECK_STATS_EN defined: 3 hits and 1 miss beforehand give hit_cnt=3 and miss_cnt=1, both cleared by the reset.
